// File: rtl/sr_arith_pkg.sv
// sr_arith_pkg: encodings shared by the hypot unit and its bench.
// ALU opcodes, request modes and FSM states.
package sr_arith_pkg;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b100;

   typedef enum logic [1:0] {
      MODE_HYP = 2'b00,
      MODE_ISQ = 2'b01,
      MODE_SUM = 2'b10,
      MODE_RSV = 2'b11
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SQ_A,
      ST_SQ_B,
      ST_ADD,
      ST_SQRT,
      ST_DONE
   } state_e;

endpackage

// File: rtl/sr_hypot_unit_if.sv
// sr_hypot_unit_if: request/result handshake bundle of the hypot unit.
// master = requester/consumer side, slave = the unit.
interface sr_hypot_unit_if #(
   parameter int W = 8
);

   localparam int RW = 2*W+2;

   logic          in_valid;
   logic          in_ready;
   logic [1:0]    mode;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] res;
   logic          err;

   modport master (
      output in_valid, mode, a, b, out_ready,
      input  in_ready, out_valid, res, err
   );

   modport slave (
      input  in_valid, mode, a, b, out_ready,
      output in_ready, out_valid, res, err
   );

endinterface

// File: rtl/sr_isqrt_core.sv
// sr_isqrt_core: restoring square-root step datapath (x, res, m).
// SR_HYPOT_ROUND_EN: round the root to nearest instead of floor.
module sr_isqrt_core #(
   parameter int RW = 18
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          load,
   input  logic          step,
   input  logic [RW-1:0] rad,
   input  logic [RW-1:0] diff,
   output logic [RW-1:0] x,
   output logic [RW-1:0] t,
   output logic [RW-1:0] root
);

   logic [RW-1:0] x_q;
   logic [RW-1:0] res_q;
   logic [RW-1:0] m_q;
   logic          ge;

   assign x  = x_q;
   assign t  = res_q | m_q;
   assign ge = x_q >= t;

   // Load the radicand, then one restoring digit per captured SUB.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_q   <= '0;
         res_q <= '0;
         m_q   <= '0;
      end else if (load) begin
         x_q   <= rad;
         res_q <= '0;
         m_q   <= {2'b01, {(RW-2){1'b0}}};
      end else if (step) begin
         if (ge) begin
            x_q   <= diff;
            res_q <= (res_q >> 1) | m_q;
         end else begin
            res_q <= res_q >> 1;
         end
         m_q <= m_q >> 2;
      end
   end

   // Remainder above the root means sqrt lies at or past root+0.5.
`ifdef SR_HYPOT_ROUND_EN
   assign root = (x_q > res_q) ? res_q + 1'b1 : res_q;
`else
   assign root = res_q;
`endif

endmodule

// File: rtl/sr_hypot_unit.sv
// sr_hypot_unit: multicycle hypot / isqrt / sum-of-squares on a shared ALU.
// SR_HYPOT_ROUND_EN: sqrt results rounded to nearest instead of floor.
module sr_hypot_unit
   import sr_arith_pkg::*;
#(
   parameter int W     = 8,
   parameter int ALU_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   sr_hypot_unit_if.slave   bus,
   output logic [2:0]       alu_op_o,
   output logic [ALU_W-1:0] alu_a_o,
   output logic [ALU_W-1:0] alu_b_o,
   input  logic [ALU_W-1:0] alu_res_i
);

   localparam int RW = 2*W+2;
   localparam int CW = $clog2(W+2);
   localparam logic [CW-1:0] LAST_SQ = CW'(W-1);
   localparam logic [CW-1:0] LAST_RT = CW'(W);

   if (ALU_W < 2*W+2) begin : g_chk
      $error("ALU_W must be at least 2*W+2");
   end

   state_e           state_q, state_d;
   mode_e            mode_q;
   logic             cap_q;
   logic [CW-1:0]    cnt_q;
   logic [W-1:0]     b_q, sh_q;
   logic [ALU_W-1:0] acc_q, md_q, sq_a_q;
   logic [RW-1:0]    sum_q, res_q;
   logic             err_q, vld_q;
   logic             accept, sq_st, op_st;
   logic             issue, capture, leave;
   logic             rt_load, rt_step;
   logic [RW-1:0]    rt_rad, rt_x, rt_t, rt_root;

   assign bus.in_ready  = state_q == ST_IDLE;
   assign bus.out_valid = vld_q;
   assign bus.res       = res_q;
   assign bus.err       = err_q;

   assign accept  = bus.in_valid && bus.in_ready;
   assign sq_st   = state_q inside {ST_SQ_A, ST_SQ_B};
   assign op_st   = sq_st || state_q inside {ST_ADD, ST_SQRT};
   assign issue   = op_st && !cap_q;
   assign capture = op_st && cap_q;
   assign leave   = state_d != state_q;

   // Phase sequencing; each op is an ISSUE cycle then a CAPTURE cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept) begin
            unique case (1'b1)
               bus.mode == MODE_ISQ: state_d = ST_SQRT;
               bus.mode == MODE_RSV: state_d = ST_DONE;
               default:              state_d = ST_SQ_A;
            endcase
         end
         ST_SQ_A: if (capture && cnt_q == LAST_SQ) state_d = ST_SQ_B;
         ST_SQ_B: if (capture && cnt_q == LAST_SQ) state_d = ST_ADD;
         ST_ADD:  if (capture)
            state_d = (mode_q == MODE_SUM) ? ST_DONE : ST_SQRT;
         ST_SQRT: if (capture && cnt_q == LAST_RT) state_d = ST_DONE;
         ST_DONE: if (vld_q && bus.out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // State, issue/capture toggle and per-phase op counter.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cap_q   <= 1'b0;
         cnt_q   <= '0;
         mode_q  <= MODE_HYP;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         if (op_st) begin
            cap_q <= ~cap_q;
            if (leave)      cnt_q <= '0;
            else if (cap_q) cnt_q <= cnt_q + 1'b1;
         end
         if (accept) begin
            mode_q <= mode_e'(bus.mode);
            b_q    <= bus.b;
         end
      end
   end

   // Shift-add squaring of a then b, followed by the sum.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q  <= '0;
         md_q   <= '0;
         sh_q   <= '0;
         sq_a_q <= '0;
         sum_q  <= '0;
      end else if (accept) begin
         acc_q <= '0;
         sh_q  <= bus.a;
         md_q  <= ALU_W'(bus.a);
      end else if (state_q == ST_SQ_A && state_d == ST_SQ_B) begin
         sq_a_q <= alu_res_i;
         acc_q  <= '0;
         sh_q   <= b_q;
         md_q   <= ALU_W'(b_q);
      end else if (sq_st && capture) begin
         acc_q <= alu_res_i;
         sh_q  <= sh_q >> 1;
         md_q  <= md_q << 1;
      end else if (state_q == ST_ADD && capture) begin
         sum_q <= alu_res_i[RW-1:0];
      end
   end

   // ALU operands are registered on ISSUE and held otherwise.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         alu_op_o <= '0;
         alu_a_o  <= '0;
         alu_b_o  <= '0;
      end else if (issue) begin
         unique case (1'b1)
            sq_st: begin
               alu_op_o <= ALU_ADD;
               alu_a_o  <= acc_q;
               alu_b_o  <= sh_q[0] ? md_q : '0;
            end
            state_q == ST_ADD: begin
               alu_op_o <= ALU_ADD;
               alu_a_o  <= sq_a_q;
               alu_b_o  <= acc_q;
            end
            default: begin
               alu_op_o <= ALU_SUB;
               alu_a_o  <= ALU_W'(rt_x);
               alu_b_o  <= ALU_W'(rt_t);
            end
         endcase
      end
   end

   assign rt_load = state_d == ST_SQRT && state_q != ST_SQRT;
   assign rt_step = capture && state_q == ST_SQRT;
   assign rt_rad  = (state_q == ST_IDLE) ? RW'(bus.a)
                                         : alu_res_i[RW-1:0];

   sr_isqrt_core #(
      .RW (RW)
   ) u_isqrt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load   (rt_load),
      .step   (rt_step),
      .rad    (rt_rad),
      .diff   (alu_res_i[RW-1:0]),
      .x      (rt_x),
      .t      (rt_t),
      .root   (rt_root)
   );

   // First DONE cycle settles the result; valid holds until taken.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= 1'b0;
         res_q <= '0;
         err_q <= 1'b0;
      end else if (state_q == ST_DONE) begin
         if (!vld_q) begin
            vld_q <= 1'b1;
            err_q <= mode_q == MODE_RSV;
            unique case (mode_q)
               MODE_SUM: res_q <= sum_q;
               MODE_RSV: res_q <= '0;
               default:  res_q <= rt_root;
            endcase
         end else if (bus.out_ready) begin
            vld_q <= 1'b0;
         end
      end
   end

endmodule
